instr_issue_sequencer: RTL and testbench
========================================

Name: instr_issue_sequencer

Overview:
- Buffers 64-bit instructions from the host side in a FIFO.
- Issues them one per cycle to the instruction decoder, which latches `instruction` every clk edge.
- Inserts NOP cycles (all-zero word, opcode 5'b00000) while the systolic array computes after a compute opcode (5'b00001 / 5'b00010).
- Halts on opcode 5'b11111 until an explicit resume.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- INSTR_W, 64, instruction width; opcode is bits [4:0].
- COMPUTE_CYCLES, 16, NOP cycles inserted after each issued compute instruction; 0 means no stall.
- CNT_W, 8, stall counter width; COMPUTE_CYCLES < 2^CNT_W.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_instr  input  INSTR_W  instruction to enqueue.
- in_valid  input  1  in_instr valid.
- in_ready  output  1  FIFO can accept; a push occurs on an edge where in_valid && in_ready.
- flush  input  1  synchronous; clears FIFO, stall and halt.
- resume  input  1  single-cycle pulse; leaves HALTED.
- issue_instr  output  INSTR_W  registered; drives the decoder's instruction input.
- issue_valid  output  1  registered; issue_instr holds a real dequeued instruction.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- stalled  output  1  state == COMPUTE_WAIT.
- halted  output  1  state == HALTED.
- busy  output  1  state != RUN or fifo_count != 0.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - FIFO pointers and count = 0; state = RUN; stall counter = 0.
  - issue_instr = 0; issue_valid = 0.
  - in_ready = 1 once rst_n is high.
- **in_ready** = (fifo_count < DEPTH) && !flush. It is combinational from registered count and flush, and does not account for a same-cycle pop.
- **Push**: writes the tail entry and increments the tail pointer (wraps modulo DEPTH).
  - Simultaneous push and pop: count unchanged.
  - Full FIFO: no push, regardless of pop.
- **No bypass**: an instruction pushed at edge t is issued no earlier than edge t+1. It is therefore visible on issue_instr after edge t+1.
- **Issue**: each edge, issue_instr/issue_valid are reloaded.
  - If state == RUN and FIFO is non-empty: pop the head; issue_instr = head; issue_valid = 1.
  - Otherwise: issue_instr = 0 (NOP) and issue_valid = 0. The output is never held, so the decoder never sees a repeated instruction.
- **States**:
  - RUN:
    - A popped head with opcode 00001 or 00010 and COMPUTE_CYCLES > 0 moves to COMPUTE_WAIT with counter = COMPUTE_CYCLES.
    - A popped head with opcode 11111 moves to HALTED.
    - Any other opcode (including unknown ones and 00000) issues normally and stays in RUN.
  - COMPUTE_WAIT:
    - The counter decrements each edge; no issue.
    - When counter == 1 at an edge, go to RUN.
    - Net timing: a compute issued at edge e is followed by exactly COMPUTE_CYCLES NOP edges; the next issue occurs at edge e+COMPUTE_CYCLES+1.
  - HALTED:
    - No issue; pushes continue until the FIFO is full.
    - resume high at an edge moves to RUN; the first issue occurs on the following edge.
    - resume in RUN or COMPUTE_WAIT is ignored.
- **flush** (priority over everything except reset):
  - On an edge with flush high: FIFO is emptied, counter = 0, state = RUN, issue_instr = 0, issue_valid = 0.
  - Push and pop are suppressed that cycle.
- **Instruction contents**: the halt instruction itself is issued to the decoder, and the compute instruction is issued before the stall. Fields other than the opcode are passed through unmodified.
- **Pointer wrap-around**: FIFO behaviour is unchanged across wrap-around. fifo_count ranges 0..DEPTH.

Test Plan:
- Reset then push three instructions with opcodes 00100, 00101, 00110 on consecutive edges → each appears on issue_instr one edge after push, issue_valid=1 for 3 consecutive cycles, then 0 with issue_instr=0.
- COMPUTE_CYCLES=16: push 00101, 00001, 00011 → 00001 issued at edge e; stalled=1 and issue_valid=0 for 16 edges; 00011 issued at edge e+17.
- Push 9 instructions while HALTED with DEPTH=8 → in_ready drops after 8, fifo_count=8, ninth not accepted until resume; after resume the first issue is on the next edge.
- Push 11111, then 00111 → halt word issued, halted=1, 00111 held; resume pulse → 00111 issued next edge; a resume pulse while in RUN has no effect.
- flush asserted mid-COMPUTE_WAIT with 5 entries queued and in_valid=1 → fifo_count=0, stalled=0, state RUN, pushed word dropped, issue_valid=0.
- Assert rst_n low asynchronously mid-issue → issue_valid, issue_instr, fifo_count immediately 0, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_issue_sequencer.sv
// -----------------------------------------------------------------------------
// instr_issue_sequencer
//
// Buffers host instructions in a FIFO and issues at most one per clock to the
// instruction decoder. After a compute opcode it inserts COMPUTE_CYCLES NOP
// cycles while the systolic array works. On a halt opcode it stops issuing
// until a resume pulse arrives.
//
// Handshake: a push happens on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered occupancy and flush, so a
// same-cycle pop never frees a slot early. The host must hold in_instr
// stable until the push edge. The issue side has no back-pressure: the
// decoder latches issue_instr on every edge. issue_valid marks the cycles
// that carry a real dequeued word. Every other cycle carries an all-zero
// NOP.
//
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   in_instr      instruction to enqueue (opcode in bits [4:0])
//   in_valid      in_instr valid
//   in_ready      FIFO can accept this cycle
//   flush         synchronous clear of FIFO, stall and halt
//   resume        single-cycle pulse that leaves the halted state
//   issue_instr   registered word presented to the decoder
//   issue_valid   registered; issue_instr is a real instruction
//   fifo_count    current FIFO occupancy (0..DEPTH)
//   stalled       waiting out a compute
//   halted        halted until resume
//   busy          not in RUN, or FIFO non-empty
// -----------------------------------------------------------------------------
module instr_issue_sequencer #(
    parameter int DEPTH          = 8,
    parameter int INSTR_W        = 64,
    parameter int COMPUTE_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       resume,
    output logic [INSTR_W-1:0]         issue_instr,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       stalled,
    output logic                       halted,
    output logic                       busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    localparam logic [4:0]        OP_COMPUTE_A = 5'b00001;
    localparam logic [4:0]        OP_COMPUTE_B = 5'b00010;
    localparam logic [4:0]        OP_HALT      = 5'b11111;
    localparam logic [CNT_W-1:0]  STALL_LOAD   = CNT_W'(COMPUTE_CYCLES);
    localparam logic [CNT_W-1:0]  STALL_ONE    = CNT_W'(1);
    localparam logic [CNT_FW-1:0] FULL_COUNT   = CNT_FW'(DEPTH);
    localparam logic [CNT_FW-1:0] COUNT_ONE    = CNT_FW'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE      = PTR_W'(1);

    // stalled and halted decode this state directly, so it is visible at the ports.
    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_COMPUTE_WAIT = 2'd1,
        ST_HALTED       = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    stall_next;

    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_FW-1:0]   count;

    logic                push;
    logic                pop;
    logic [INSTR_W-1:0]  head;
    logic [4:0]          head_op;
    logic                head_is_compute;

    assign in_ready        = (count < FULL_COUNT) && !flush;
    assign push            = in_valid && in_ready;
    assign pop             = !flush && (state == ST_RUN) && (count != '0);
    assign head            = mem[rd_ptr];
    assign head_op         = head[4:0];
    assign head_is_compute = (head_op == OP_COMPUTE_A) || (head_op == OP_COMPUTE_B);

    // Next-state and stall counter logic.
    always_comb begin
        state_next = state;
        stall_next = stall_cnt;
        if (flush) begin
            state_next = ST_RUN;
            stall_next = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pop) begin
                        if (head_is_compute && (COMPUTE_CYCLES != 0)) begin
                            state_next = ST_COMPUTE_WAIT;
                            stall_next = STALL_LOAD;
                        end else if (head_op == OP_HALT) begin
                            state_next = ST_HALTED;
                        end
                    end
                end
                ST_COMPUTE_WAIT: begin
                    // The last NOP edge is the one that sees a count of 1.
                    // A count of zero here is unreachable but still returns to RUN.
                    if (stall_cnt <= STALL_ONE) begin
                        state_next = ST_RUN;
                        stall_next = '0;
                    end else begin
                        stall_next = stall_cnt - STALL_ONE;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    stall_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_next;
        end
    end

    // FIFO storage has no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap without explicit compares.
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The issue register is reloaded every edge. It never holds an old word,
    // so the decoder never sees the same instruction twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_instr <= '0;
            issue_valid <= 1'b0;
        end else if (pop) begin
            issue_instr <= head;
            issue_valid <= 1'b1;
        end else begin
            issue_instr <= '0;
            issue_valid <= 1'b0;
        end
    end

    assign fifo_count = count;
    assign stalled    = (state == ST_COMPUTE_WAIT);
    assign halted     = (state == ST_HALTED);
    assign busy       = (state != ST_RUN) || (count != '0);

endmodule

// File: tb/tb_instr_issue_sequencer.sv
`timescale 1ns/1ps
module tb_instr_issue_sequencer;

  localparam int DEPTH          = 8;
  localparam int INSTR_W        = 64;
  localparam int COMPUTE_CYCLES = 16;
  localparam int CNT_W          = 8;
  localparam int W              = INSTR_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [INSTR_W-1:0]   in_instr = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 flush = 1'b0;
  logic                 resume = 1'b0;
  logic [INSTR_W-1:0]   issue_instr;
  logic                 issue_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 stalled;
  logic                 halted;
  logic                 busy;

  instr_issue_sequencer #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W), .COMPUTE_CYCLES(COMPUTE_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .resume(resume),
    .issue_instr(issue_instr), .issue_valid(issue_valid),
    .fifo_count(fifo_count), .stalled(stalled), .halted(halted), .busy(busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0]       exp_q[$];   // {valid, word} expected after each edge
  logic [INSTR_W-1:0] m_q[$];     // model FIFO contents
  int                 m_stall = 0; // NOP edges still owed
  bit                 m_halted = 0;
  bit                 last_accepted = 0;
  bit                 mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [4:0] op);
    logic [INSTR_W-1:0] r;
    r = {$urandom, $urandom};
    r[4:0] = op;
    return r;
  endfunction

  // One clock edge of the reference behaviour, using the inputs the driver presented.
  task automatic model_edge();
    logic [INSTR_W-1:0] w;
    bit can_push;
    last_accepted = 0;
    if (flush) begin
      m_q.delete();
      m_stall  = 0;
      m_halted = 0;
      exp_q.push_back('0);
    end else begin
      can_push = in_valid && (m_q.size() < DEPTH);
      if (!m_halted && m_stall == 0 && m_q.size() > 0) begin
        w = m_q.pop_front();
        exp_q.push_back({1'b1, w});
        if ((w[4:0] == 5'd1 || w[4:0] == 5'd2) && COMPUTE_CYCLES > 0) m_stall = COMPUTE_CYCLES;
        else if (w[4:0] == 5'h1f) m_halted = 1;
      end else begin
        exp_q.push_back('0);
        if (m_stall > 0) m_stall--;
        else if (m_halted && resume) m_halted = 0;
      end
      if (can_push) m_q.push_back(in_instr);
      last_accepted = can_push;
    end
  endtask

  // Monitor: compares one expected issue per edge plus status outputs.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_valid", issue_valid, e[W-1]);
        chk("issue_instr", issue_instr, e[INSTR_W-1:0]);
      end
      chk("fifo_count", fifo_count, m_q.size());
      chk("in_ready", in_ready, (m_q.size() < DEPTH) && !flush);
      chk("stalled", stalled, m_stall > 0);
      chk("halted", halted, m_halted);
      chk("busy", busy, (m_stall > 0) || m_halted || (m_q.size() != 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input logic [INSTR_W-1:0] w, input bit fl = 0, input bit rs = 0);
    in_valid = v;
    in_instr = w;
    flush    = fl;
    resume   = rs;
    @(posedge clk);
    model_edge();
    #1;
    in_valid = 0;
    flush    = 0;
    resume   = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0);
  endtask

  // Asserts reset immediately (mid-cycle allowed) and checks the asynchronous clear.
  task automatic do_reset();
    mon_en = 0;
    in_valid = 0; flush = 0; resume = 0;
    rst_n = 0;
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_fifo_count", fifo_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    exp_q.delete();
    m_q.delete();
    m_stall = 0;
    m_halted = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_halted", halted, 0);
    mon_en = 1;
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [INSTR_W-1:0] w9;
    int tries;
    bit v, fl, rs;
    int r;
    logic [4:0] op;

    do_reset();

    // Three plain instructions back to back.
    cycle(1, mk(5'b00100));
    cycle(1, mk(5'b00101));
    cycle(1, mk(5'b00110));
    idle(4);

    // Compute stall.
    cycle(1, mk(5'b00101));
    cycle(1, mk(5'b00001));
    cycle(1, mk(5'b00011));
    idle(22);

    // Halt then resume; resume in RUN is ignored.
    cycle(1, mk(5'b11111));
    cycle(1, mk(5'b00111));
    idle(3);
    chk("halt_halted", halted, 1);
    chk("halt_held", fifo_count, 1);
    cycle(0, '0, 0, 1);
    idle(2);
    cycle(0, '0, 0, 1);
    idle(2);
    chk("resume_in_run", halted, 0);

    // Fill while halted.
    cycle(1, mk(5'b11111));
    for (int i = 0; i < 8; i++) cycle(1, mk(5'(8 + i)));
    chk("full_count", fifo_count, 8);
    chk("full_ready", in_ready, 0);
    w9 = mk(5'b01001);
    repeat (3) cycle(1, w9);
    chk("ninth_rejected", fifo_count, 8);
    cycle(1, w9, 0, 1);
    tries = 0;
    do begin
      cycle(1, w9);
      tries++;
    end while (!last_accepted && tries < 10);
    chk("ninth_accepted", last_accepted, 1);
    idle(14);

    // Flush in the middle of a compute wait.
    cycle(1, mk(5'b00010));
    for (int i = 0; i < 5; i++) cycle(1, mk(5'b00100));
    chk("pre_flush_count", fifo_count, 5);
    cycle(1, mk(5'b00100), 1, 0);
    chk("flush_count", fifo_count, 0);
    chk("flush_stalled", stalled, 0);
    chk("flush_issue_valid", issue_valid, 0);
    idle(3);

    // Asynchronous reset while issuing.
    cycle(1, mk(5'b00100));
    cycle(1, mk(5'b00110));
    cycle(1, mk(5'b01001));
    chk("pre_rst_issue_valid", issue_valid, 1);
    #2;
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 900; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 15);
      if (r < 2)       op = 5'(r + 1);
      else if (r == 2) op = 5'h1f;
      else if (r == 3) op = 5'h00;
      else             op = 5'($urandom_range(3, 30));
      fl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 7) == 0);
      cycle(v, mk(op), fl, rs);
    end
    idle(4);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
